// File: rtl/sigmoid_req_scheduler.sv
// rtl/sigmoid_req_scheduler.sv - round-robin sharing of one sigmoid_taylor core with sign folding
module sigmoid_req_scheduler #(
    parameter int          N_REQ    = 2,
    parameter int          W        = 12,
    parameter int          CORE_LAT = 2,
    parameter int unsigned SAT_MAG  = 32'h800
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_x,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   resp_valid,
    output logic [W-1:0]       resp_f,
    input  logic [N_REQ-1:0]   resp_ready,
    output logic [W-1:0]       core_x,
    input  logic [W-1:0]       core_f,
    output logic               busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [W-1:0] ONE = W'(1024);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   r_id;
    logic            r_sign;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_core_x;
    logic [W-1:0]    r_resp_f;

    logic            w_gnt_found;
    logic [IW-1:0]   w_gnt_idx;
    logic [IW-1:0]   w_scan_idx;
    logic [W-1:0]    w_sel_x;
    logic [W-1:0]    w_mag;
    logic            w_sat;
    logic            w_accept;
    logic [IW-1:0]   w_rr_nxt;
    logic [W-1:0]    w_core_clamp;
    logic [W-1:0]    w_core_fold;

    // First asserted requester at or after the round-robin pointer, searching cyclically.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan_idx = IW'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_gnt_found && req_valid[w_scan_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_sel_x = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_gnt_idx == IW'(k)) begin
                w_sel_x = req_x[k*W +: W];
            end
        end
    end

    // Two's-complement negate in W bits; the most negative input folds onto itself and saturates.
    assign w_mag        = w_sel_x[W-1] ? (~w_sel_x + 1'b1) : w_sel_x;
    assign w_sat        = 32'(w_mag) >= SAT_MAG;
    assign w_accept     = (r_state == S_IDLE) && w_gnt_found;
    assign w_rr_nxt     = (w_gnt_idx == IW'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_core_clamp = (core_f > ONE) ? ONE : core_f;
    assign w_core_fold  = r_sign ? (ONE - w_core_clamp) : w_core_clamp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        resp_valid  = '0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by reset_n so the grant is silent while reset is held.
                if (w_gnt_found && reset_n) begin
                    req_ready = N_REQ'(1) << w_gnt_idx;
                end
                if (w_accept) begin
                    w_state_nxt = w_sat ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                busy       = 1'b1;
                resp_valid = N_REQ'(1) << r_id;
                if (resp_ready[r_id]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_sign   <= 1'b0;
            r_cnt    <= '0;
            r_core_x <= '0;
            r_resp_f <= '0;
        end else begin
            if (w_accept) begin
                r_sign   <= w_sel_x[W-1];
                r_id     <= w_gnt_idx;
                r_rr_ptr <= w_rr_nxt;
                if (w_sat) begin
                    r_resp_f <= w_sel_x[W-1] ? '0 : ONE;
                end else begin
                    r_core_x <= w_mag;
                    r_cnt    <= CW'(CORE_LAT - 1);
                end
            end else if (r_state == S_WAIT) begin
                if (r_cnt == '0) begin
                    r_resp_f <= w_core_fold;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign core_x = r_core_x;
    assign resp_f = r_resp_f;

endmodule

// File: tb/tb_sigmoid_req_scheduler.sv
// tb/tb_sigmoid_req_scheduler.sv - directed bench for sigmoid_req_scheduler with a behavioural core
module tb_sigmoid_req_scheduler;

    localparam int N = 2;
    localparam int W = 12;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_x;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_f;
    logic [N-1:0]   resp_ready;
    logic [W-1:0]   core_x;
    logic [W-1:0]   core_f;
    logic           busy;
    logic           force_big;

    int n_cmp = 0;
    int n_err = 0;

    sigmoid_req_scheduler #(
        .N_REQ    (N),
        .W        (W),
        .CORE_LAT (2),
        .SAT_MAG  (32'h800)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_f     (resp_f),
        .resp_ready (resp_ready),
        .core_x     (core_x),
        .core_f     (core_f),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic int ref_f(input int m);
        return $rtoi(1024.0 / (1.0 + $exp(-real'(m) / 256.0)) + 0.5);
    endfunction

    // Core stand-in: result valid two edges after core_x changes.
    always @(posedge clk) begin
        core_f <= force_big ? 12'd1100 : 12'(ref_f(int'(core_x)));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic xact(input int idx, input logic [W-1:0] x,
                        output logic [W-1:0] f, output int lat);
        int n;
        req_valid[idx] = 1'b1;
        req_x[idx*W +: W] = x;
        #1;
        n = 0;
        while (req_ready[idx] !== 1'b1 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("grant", req_ready[idx], 1);
        @(negedge clk);
        req_valid[idx] = 1'b0;
        req_x[idx*W +: W] = ~x;
        lat = 1;
        while (resp_valid[idx] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        f = resp_f;
        resp_ready[idx] = 1'b1;
        @(negedge clk);
        resp_ready[idx] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] f;
        logic [W-1:0] f_hold;
        int lat;
        int n;
        int n_g;
        int gnt[4];
        int neg_f[2048];
        real s;
        real e;

        reset_n    = 1'b0;
        req_valid  = 2'b11;
        req_x      = '0;
        resp_ready = '0;
        force_big  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_core_x", core_x, 0);
        chk("rst_resp_f", resp_f, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        req_valid = '0;
        reset_n   = 1'b1;
        @(negedge clk);

        xact(0, 12'h280, f, lat);
        chk("pos_f", f, 946);
        chk("pos_lat", lat, 3);
        chk("pos_core_x", core_x, 12'h280);
        chk("pos_idle", busy, 0);

        xact(1, 12'hD80, f, lat);
        chk("neg_f", f, 78);
        chk("neg_lat", lat, 3);
        chk("neg_core_x", core_x, 12'h280);

        xact(0, 12'h800, f, lat);
        chk("sat_f", f, 0);
        chk("sat_lat", lat, 1);
        chk("sat_core_x", core_x, 12'h280);

        force_big = 1'b1;
        xact(1, 12'h7FF, f, lat);
        chk("clamp_pos_f", f, 1024);
        chk("clamp_pos_lat", lat, 3);
        chk("clamp_core_x", core_x, 12'h7FF);
        xact(0, 12'hFFF, f, lat);
        chk("clamp_neg_f", f, 0);
        chk("clamp_neg_core_x", core_x, 12'h001);
        force_big = 1'b0;

        xact(1, 12'h000, f, lat);
        chk("zero_f", f, 512);
        chk("zero_core_x", core_x, 0);

        // Backpressure on the response while another requester waits.
        req_valid[0] = 1'b1;
        req_x[0 +: W] = 12'h100;
        #1;
        chk("bp_grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1;
        req_x[W +: W] = 12'h280;
        n = 0;
        while (resp_valid[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        f_hold = resp_f;
        chk("bp_f", f_hold, 749);
        resp_ready[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_resp_valid", resp_valid, 2'b01);
            chk("bp_resp_f", resp_f, f_hold);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_busy", busy, 1);
        end
        resp_ready = 2'b01;
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        chk("bp_exit_busy", busy, 0);
        chk("bp_exit_resp_valid", resp_valid, 0);
        chk("bp_exit_req_ready", req_ready, 2'b10);
        @(negedge clk);
        req_valid[1] = 1'b0;
        n = 0;
        while (resp_valid[1] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_second_f", resp_f, 946);
        resp_ready[1] = 1'b1;
        @(negedge clk);
        resp_ready[1] = 1'b0;

        // Reset in the middle of WAIT drops the operation.
        req_valid[0] = 1'b1;
        req_x[0 +: W] = 12'h280;
        #1;
        chk("mid_grant", req_ready, 2'b01);
        @(negedge clk);
        chk("mid_busy", busy, 1);
        req_valid = 2'b11;
        req_x     = {12'h100, 12'h100};
        reset_n   = 1'b0;
        #1;
        chk("mid_rst_core_x", core_x, 0);
        chk("mid_rst_resp_f", resp_f, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_grant", req_ready, 2'b01);

        // Both requesters held valid: grants must alternate.
        n_g = 0;
        n = 0;
        while (n_g < 4 && n < 60) begin
            resp_ready = resp_valid;
            chk("rr_onehot_ready", $onehot0(req_ready), 1);
            chk("rr_onehot_resp", $onehot0(resp_valid), 1);
            if (resp_valid != 0) begin
                chk("rr_f", resp_f, 749);
            end
            if (req_ready != 0) begin
                chk("rr_idle_on_grant", busy, 0);
                gnt[n_g] = req_ready[1] ? 1 : 0;
                n_g++;
            end
            @(negedge clk); #1;
            n++;
        end
        chk("rr_count", n_g, 4);
        chk("rr_g0", gnt[0], 0);
        chk("rr_g1", gnt[1], 1);
        chk("rr_g2", gnt[2], 0);
        chk("rr_g3", gnt[3], 1);
        req_valid = '0;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            resp_ready = resp_valid;
            @(negedge clk); #1;
            n++;
        end
        resp_ready = '0;
        chk("rr_drain", busy, 0);
        @(negedge clk);

        // Sweep -8.0 .. +8.0 in steps of 4 LSB.
        for (int x = -2048; x < 2048; x += 4) begin
            xact(0, 12'(x), f, lat);
            s = 1024.0 / (1.0 + $exp(-real'(x) / 256.0));
            e = real'(f) - s;
            if (e < 0.0) e = -e;
            chk("sweep_err", (e <= 1.0) ? 1 : 0, 1);
            if (x < 0) begin
                neg_f[-x] = int'(f);
            end else if (x > 0) begin
                chk("sweep_mirror", neg_f[x] + int'(f), 1024);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
